// File: rtl/step_decoder_if.sv
// Step/dir decoder bus: step/dir pins and host controls in, position and speed readback out.
interface step_decoder_if #(
    parameter int POS_W = 32,
    parameter int PER_W = 24
);
    logic                    step_in;
    logic                    dir_in;
    logic                    set_pos;
    logic signed [POS_W-1:0] pos_val;
    logic [PER_W-1:0]        timeout_val;
    logic                    clear_err;
    logic signed [POS_W-1:0] pos;
    logic [PER_W-1:0]        period;
    logic                    period_valid;
    logic                    dir;
    logic                    step_seen;
    logic                    moving;
    logic                    err_setup;

    modport master (
        output step_in, dir_in, set_pos, pos_val, timeout_val, clear_err,
        input  pos, period, period_valid, dir, step_seen, moving, err_setup
    );

    modport slave (
        input  step_in, dir_in, set_pos, pos_val, timeout_val, clear_err,
        output pos, period, period_valid, dir, step_seen, moving, err_setup
    );
endinterface

// File: rtl/step_decoder.sv
// Step/dir input decoder: synchronizes step/dir, counts position, measures step period, detects timeout.
// Optional dir-setup violation checker enabled by defining STEP_DECODER_SETUP_CHECK_EN.
module step_decoder #(
    parameter int POS_W       = 32,
    parameter int PER_W       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int DIR_SETUP   = 4
) (
    input logic           clk,
    input logic           reset,
    step_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FIRST, RUN} state_t;

    localparam logic [PER_W-1:0] CNT_MAX = '1;

    function automatic logic [PER_W-1:0] sat_inc(input logic [PER_W-1:0] v);
        return (v == CNT_MAX) ? v : v + PER_W'(1);
    endfunction

    logic [SYNC_STAGES-1:0]  step_sync;
    logic [SYNC_STAGES-1:0]  dir_sync;
    logic [SYNC_STAGES-1:0]  fill;
    logic                    prev;
    logic                    sync_step;
    logic                    sync_dir;
    logic                    step_edge;
    logic                    timeout_hit;
    state_t                  state;
    logic signed [POS_W-1:0] pos;
    logic [PER_W-1:0]        cnt;
    logic [PER_W-1:0]        period;
    logic                    period_valid;
    logic                    dir;
    logic                    step_seen;
    logic                    moving;
    logic                    err_setup;

    assign sync_step   = step_sync[SYNC_STAGES-1];
    assign sync_dir    = dir_sync[SYNC_STAGES-1];
    assign step_edge   = sync_step & ~prev;
    assign timeout_hit = (bus.timeout_val != '0) && (cnt >= bus.timeout_val);

    // Synchronizer stage; prev is held high until the chain has refilled after reset,
    // so a step_in that is already high needs a fresh rising edge to count.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_sync <= '0;
            dir_sync  <= '0;
            fill      <= '0;
            prev      <= 1'b0;
        end else begin
            step_sync <= {step_sync[SYNC_STAGES-2:0], bus.step_in};
            dir_sync  <= {dir_sync[SYNC_STAGES-2:0], bus.dir_in};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            prev      <= fill[SYNC_STAGES-1] ? sync_step : 1'b1;
        end
    end

    // Decode stage: position, gap counter and motion state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pos          <= '0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            dir          <= 1'b0;
            step_seen    <= 1'b0;
            moving       <= 1'b0;
        end else begin
            step_seen <= step_edge;
            cnt       <= step_edge ? PER_W'(1) : sat_inc(cnt);

            if (bus.set_pos)
                pos <= bus.pos_val;
            else if (step_edge)
                pos <= sync_dir ? pos - POS_W'(1) : pos + POS_W'(1);

            if (step_edge) begin
                dir <= sync_dir;
                unique case (state)
                    IDLE: begin
                        state  <= FIRST;
                        moving <= 1'b1;
                    end
                    FIRST: begin
                        if (sync_dir == dir) begin
                            state        <= RUN;
                            period       <= cnt;
                            period_valid <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (sync_dir == dir) begin
                            period <= cnt;
                        end else begin
                            state        <= FIRST;
                            period_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        moving <= 1'b0;
                    end
                endcase
            end else if (state != IDLE && timeout_hit) begin
                state        <= IDLE;
                moving       <= 1'b0;
                period_valid <= 1'b0;
            end
        end
    end

`ifdef STEP_DECODER_SETUP_CHECK_EN
    localparam int DSU_W = $clog2(DIR_SETUP + 1);
    localparam logic [DSU_W-1:0] DSU_MAX = DSU_W'(DIR_SETUP);

    logic [DSU_W-1:0] dsu_cnt;
    logic             dir_prev;
    logic             dir_armed;
    logic             dir_change;

    // A dir change seen while the synchronizer refills is not a real transition.
    assign dir_change = dir_armed & (sync_dir != dir_prev);

    always_ff @(posedge clk) begin
        if (reset) begin
            dsu_cnt   <= DSU_MAX;
            dir_prev  <= 1'b0;
            dir_armed <= 1'b0;
            err_setup <= 1'b0;
        end else begin
            dir_prev  <= sync_dir;
            dir_armed <= fill[SYNC_STAGES-1];
            if (dir_change)
                dsu_cnt <= DSU_W'(1);
            else if (dsu_cnt < DSU_MAX)
                dsu_cnt <= dsu_cnt + DSU_W'(1);
            if (step_edge && (dir_change || dsu_cnt < DSU_MAX))
                err_setup <= 1'b1;
            else if (bus.clear_err)
                err_setup <= 1'b0;
        end
    end
`else
    logic unused_clear_err;
    assign unused_clear_err = bus.clear_err;
    assign err_setup        = 1'b0;
`endif

    assign bus.pos          = pos;
    assign bus.period       = period;
    assign bus.period_valid = period_valid;
    assign bus.dir          = dir;
    assign bus.step_seen    = step_seen;
    assign bus.moving       = moving;
    assign bus.err_setup    = err_setup;
endmodule

// File: tb/tb_step_decoder.sv
// Self-checking bench for step_decoder: step-event reference model with randomized step trains.
module tb_step_decoder;
    localparam int POS_W       = 32;
    localparam int PER_W       = 24;
    localparam int SYNC_STAGES = 2;
    localparam int DIR_SETUP   = 4;
    localparam int M_IDLE  = 0;
    localparam int M_FIRST = 1;
    localparam int M_RUN   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    step_decoder_if #(.POS_W(POS_W), .PER_W(PER_W)) bus();

    step_decoder #(
        .POS_W(POS_W), .PER_W(PER_W), .SYNC_STAGES(SYNC_STAGES), .DIR_SETUP(DIR_SETUP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int seen_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.step_seen === 1'b1) seen_cnt <= seen_cnt + 1;

    // Reference model, updated once per step at event level
    logic signed [POS_W-1:0] m_pos;
    logic [PER_W-1:0]        m_period;
    bit                      m_dir;
    bit                      m_valid;
    bit                      m_err;
    int                      m_state;
    int                      m_last;
    int                      m_tv;

    function void model_reset();
        m_pos = '0; m_period = '0; m_dir = 0; m_valid = 0; m_err = 0;
        m_state = M_IDLE; m_last = 0;
    endfunction

    function void model_edge(bit d, int rc, bit load, logic signed [POS_W-1:0] val);
        if (m_state != M_IDLE && m_tv != 0 && (rc - m_last) > m_tv) begin
            m_state = M_IDLE;
            m_valid = 0;
        end
        if (load) m_pos = val;
        else      m_pos = d ? m_pos - 1 : m_pos + 1;
        if (m_state == M_IDLE) begin
            m_state = M_FIRST;
        end else if (d == m_dir) begin
            m_state  = M_RUN;
            m_period = PER_W'(rc - m_last);
            m_valid  = 1;
        end else if (m_state == M_RUN) begin
            m_state = M_FIRST;
            m_valid = 0;
        end
        m_dir  = d;
        m_last = rc;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One step: dir set 'pre' cycles before the rise, high 4 cycles, then 'low' idle cycles
    task automatic pulse(input bit d, input int pre, input int low, input bit load,
                         input logic signed [POS_W-1:0] val);
        int rc;
`ifdef STEP_DECODER_SETUP_CHECK_EN
        if (d != bus.dir_in && pre < DIR_SETUP) m_err = 1;
`endif
        bus.dir_in = d;
        tick(pre);
        bus.step_in = 1'b1;
        rc = cyc;
        tick(2);
        if (load) begin
            bus.set_pos = 1'b1;
            bus.pos_val = val;
        end
        @(negedge clk);
        n_cmp++;
        if (bus.step_seen !== 1'b0) begin
            n_bad++; $display("FAIL step_seen_early: got %0b, expected 0", bus.step_seen);
        end
        tick(1);
        bus.set_pos = 1'b0;
        model_edge(d, rc, load, val);
        @(negedge clk);
        n_cmp++;
        if (bus.step_seen !== 1'b1) begin
            n_bad++; $display("FAIL step_seen: got %0b, expected 1", bus.step_seen);
        end
        n_cmp++;
        if (bus.pos !== m_pos) begin
            n_bad++; $display("FAIL pos: got %0d, expected %0d", bus.pos, m_pos);
        end
        n_cmp++;
        if (bus.dir !== m_dir) begin
            n_bad++; $display("FAIL dir: got %0b, expected %0b", bus.dir, m_dir);
        end
        n_cmp++;
        if (bus.period_valid !== m_valid) begin
            n_bad++; $display("FAIL period_valid: got %0b, expected %0b", bus.period_valid, m_valid);
        end
        n_cmp++;
        if (bus.period !== m_period) begin
            n_bad++; $display("FAIL period: got %0d, expected %0d", bus.period, m_period);
        end
        n_cmp++;
        if (bus.moving !== (m_state != M_IDLE)) begin
            n_bad++; $display("FAIL moving: got %0b, expected %0b", bus.moving, m_state != M_IDLE);
        end
        n_cmp++;
        if (bus.err_setup !== m_err) begin
            n_bad++; $display("FAIL err_setup: got %0b, expected %0b", bus.err_setup, m_err);
        end
        tick(1);
        bus.step_in = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.step_seen !== 1'b0) begin
            n_bad++; $display("FAIL step_seen_width: got %0b, expected 0", bus.step_seen);
        end
        tick(low);
    endtask

    task automatic check_idle_outputs(input string tag);
        n_cmp++;
        if ({bus.pos, bus.period} !== '0) begin
            n_bad++; $display("FAIL %s_pos_period: got %0d/%0d, expected 0/0", tag, bus.pos, bus.period);
        end
        n_cmp++;
        if ({bus.period_valid, bus.dir, bus.step_seen, bus.moving, bus.err_setup} !== 5'b0) begin
            n_bad++; $display("FAIL %s_flags: got %b, expected 00000", tag,
                              {bus.period_valid, bus.dir, bus.step_seen, bus.moving, bus.err_setup});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_idle_outputs("reset");
    endtask

    task automatic test_basic();
        int s0;
        s0 = seen_cnt;
        for (int i = 0; i < 5; i++) pulse(1'b0, 6, 0, 1'b0, '0);
        tick(2);
        n_cmp++;
        if (bus.pos !== 32'sd5 || bus.period !== 24'd10) begin
            n_bad++; $display("FAIL basic_pos_period: got %0d/%0d, expected 5/10", bus.pos, bus.period);
        end
        n_cmp++;
        if (seen_cnt - s0 !== 5) begin
            n_bad++; $display("FAIL basic_seen_count: got %0d, expected 5", seen_cnt - s0);
        end
    endtask

    task automatic test_reversal();
        for (int i = 0; i < 3; i++) pulse(1'b0, 6, 0, 1'b0, '0);
        pulse(1'b1, 8, 0, 1'b0, '0);
        pulse(1'b1, 8, 0, 1'b0, '0);
        n_cmp++;
        if (bus.period !== 24'd12 || bus.period_valid !== 1'b1) begin
            n_bad++; $display("FAIL reversal_period: got %0d/%0b, expected 12/1", bus.period, bus.period_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            pulse(1'($urandom_range(0, 1)), $urandom_range(5, 8), $urandom_range(0, 10), 1'b0, '0);
    endtask

    task automatic test_timeout();
        m_tv = 50;
        bus.timeout_val = 24'd50;
        for (int i = 0; i < 4; i++) pulse(1'b0, 6, 0, 1'b0, '0);
        tick(48);
        @(negedge clk);
        n_cmp++;
        if (bus.moving !== 1'b1 || bus.period_valid !== 1'b1) begin
            n_bad++; $display("FAIL timeout_early: got %0b/%0b, expected 1/1", bus.moving, bus.period_valid);
        end
        tick(1);
        @(negedge clk);
        n_cmp++;
        if (bus.moving !== 1'b0 || bus.period_valid !== 1'b0) begin
            n_bad++; $display("FAIL timeout_fall: got %0b/%0b, expected 0/0", bus.moving, bus.period_valid);
        end
        n_cmp++;
        if (bus.pos !== m_pos) begin
            n_bad++; $display("FAIL timeout_pos: got %0d, expected %0d", bus.pos, m_pos);
        end
        m_state = M_IDLE;
        m_valid = 0;
        m_tv = 0;
        bus.timeout_val = '0;
        tick(1);
    endtask

    task automatic test_set_pos();
        logic signed [POS_W-1:0] lo;
        lo = {1'b1, {(POS_W-1){1'b0}}};
        bus.set_pos = 1'b1;
        bus.pos_val = lo;
        tick(1);
        bus.set_pos = 1'b0;
        m_pos = lo;
        @(negedge clk);
        n_cmp++;
        if (bus.pos !== lo) begin
            n_bad++; $display("FAIL set_pos_load: got %0d, expected %0d", bus.pos, lo);
        end
        pulse(1'b1, 6, 2, 1'b0, '0);
        n_cmp++;
        if (bus.pos !== 32'sh7fffffff) begin
            n_bad++; $display("FAIL set_pos_wrap: got %0d, expected 2147483647", bus.pos);
        end
        pulse(1'b0, 6, 2, 1'b1, 32'sd100);
        n_cmp++;
        if (bus.pos !== 32'sd100) begin
            n_bad++; $display("FAIL set_pos_coincident: got %0d, expected 100", bus.pos);
        end
    endtask

    task automatic test_setup();
        bit nd;
        nd = ~bus.dir_in;
        pulse(nd, 2, 2, 1'b0, '0);
        bus.clear_err = 1'b1;
        tick(1);
        bus.clear_err = 1'b0;
        m_err = 0;
        @(negedge clk);
        n_cmp++;
        if (bus.err_setup !== 1'b0) begin
            n_bad++; $display("FAIL setup_clear: got %0b, expected 0", bus.err_setup);
        end
        nd = ~bus.dir_in;
        pulse(nd, 4, 2, 1'b0, '0);
        n_cmp++;
        if (bus.err_setup !== 1'b0) begin
            n_bad++; $display("FAIL setup_ok: got %0b, expected 0", bus.err_setup);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) pulse(1'b0, 6, 2, 1'b0, '0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_idle_outputs("reset_mid");
        pulse(1'b0, 6, 2, 1'b0, '0);
        n_cmp++;
        if (bus.pos !== 32'sd1 || bus.period_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_step: got %0d/%0b, expected 1/0", bus.pos, bus.period_valid);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.step_in     = 1'b0;
        bus.dir_in      = 1'b0;
        bus.set_pos     = 1'b0;
        bus.pos_val     = '0;
        bus.timeout_val = '0;
        bus.clear_err   = 1'b0;
        m_tv = 0;
        model_reset();
        test_reset();
        test_basic();
        test_reversal();
        test_random();
        test_timeout();
        test_set_pos();
        test_setup();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
